// File: rtl/compare_search_pkg.sv
// rtl/compare_search_pkg.sv - shared constants and state encoding for the compare_search block
package compare_search_pkg;

    localparam int W_DEF   = 4;
    localparam int TMO_DEF = 15;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_PROBE  = 2'd1;
    localparam logic [1:0] ST_UPDATE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    // A usable comparator answer raises exactly one of {gt, lt, eq}.
    function automatic logic flags_onehot(input logic [2:0] f);
        return (f == 3'b001) || (f == 3'b010) || (f == 3'b100);
    endfunction

endpackage

// File: rtl/compare_search_if.sv
// rtl/compare_search_if.sv - probe/response handshake between the searcher and an external comparator
interface compare_search_if #(
    parameter int W = compare_search_pkg::W_DEF
);
    logic [W-1:0] A;
    logic         probe_valid;
    logic         resp_valid;
    logic         A_gt_B;
    logic         A_lt_B;
    logic         A_eq_B;

    modport master (
        output A, probe_valid,
        input  resp_valid, A_gt_B, A_lt_B, A_eq_B
    );

    modport slave (
        input  A, probe_valid,
        output resp_valid, A_gt_B, A_lt_B, A_eq_B
    );
endinterface

// File: rtl/compare_search.sv
// rtl/compare_search.sv - binary search of a hidden operand through an external magnitude comparator
module compare_search
    import compare_search_pkg::*;
#(
    parameter  int W   = W_DEF,
    parameter  int TMO = TMO_DEF,
    localparam int NPW = $clog2(W + 2),
    localparam int TW  = $clog2(TMO + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    compare_search_if.master     cmp,
    output logic                 busy,
    output logic                 done,
    output logic [W-1:0]         result,
    output logic                 err,
    output logic [NPW-1:0]       nprobes
);

    logic [1:0]     state_q, state_d;
    logic [W:0]     lo_q, lo_d;
    logic [W:0]     hi_q, hi_d;
    logic [TW-1:0]  tmo_q, tmo_d;
    logic [2:0]     flags_q, flags_d;
    logic [W-1:0]   result_q, result_d;
    logic           err_q, err_d;
    logic           done_q, done_d;
    logic [NPW-1:0] np_q, np_d;

    logic [W:0]     sum_w;
    logic [W-1:0]   a_w;
    logic [W:0]     a_ext;
    logic [W:0]     lo_inc;
    logic [W:0]     hi_dec;

    // lo/hi never change between PROBE and UPDATE, so the probe stays stable and is reused there.
    assign sum_w  = lo_q + hi_q;
    assign a_w    = W'(sum_w >> 1);
    assign a_ext  = {1'b0, a_w};
    assign lo_inc = a_ext + (W+1)'(1);
    assign hi_dec = a_ext - (W+1)'(1);

    assign cmp.A           = a_w;
    assign cmp.probe_valid = (state_q == ST_PROBE);
    assign busy            = (state_q == ST_PROBE) || (state_q == ST_UPDATE);
    assign done            = done_q;
    assign result          = result_q;
    assign err             = err_q;
    assign nprobes         = np_q;

    always_comb begin
        state_d  = state_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        tmo_d    = tmo_q;
        flags_d  = flags_q;
        result_d = result_q;
        err_d    = err_q;
        np_d     = np_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    lo_d    = '0;
                    hi_d    = {1'b0, {W{1'b1}}};
                    err_d   = 1'b0;
                    np_d    = '0;
                    tmo_d   = '0;
                    state_d = ST_PROBE;
                end
            end
            ST_PROBE: begin
                if (cmp.resp_valid) begin
                    flags_d = {cmp.A_gt_B, cmp.A_lt_B, cmp.A_eq_B};
                    np_d    = np_q + NPW'(1);
                    state_d = ST_UPDATE;
                end else if (tmo_q == TW'(TMO - 1)) begin
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            ST_UPDATE: begin
                tmo_d   = '0;
                state_d = ST_PROBE;
                if (!flags_onehot(flags_q)) begin
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else if (flags_q[0]) begin
                    result_d = a_w;
                    done_d   = 1'b1;
                    state_d  = ST_DONE;
                end else if (flags_q[2]) begin
                    // hi = A-1 would drop below lo exactly when A <= lo.
                    if (a_ext <= lo_q) begin
                        err_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        hi_d = hi_dec;
                    end
                end else begin
                    if (lo_inc > hi_q) begin
                        err_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        lo_d = lo_inc;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            lo_q     <= '0;
            hi_q     <= '0;
            tmo_q    <= '0;
            flags_q  <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
            np_q     <= '0;
        end else begin
            state_q  <= state_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            tmo_q    <= tmo_d;
            flags_q  <= flags_d;
            result_q <= result_d;
            err_q    <= err_d;
            done_q   <= done_d;
            np_q     <= np_d;
        end
    end

endmodule

// File: tb/tb_compare_search.sv
// tb/tb_compare_search.sv - randomized self-checking bench for compare_search with a comparator model
module tb_compare_search;
    import compare_search_pkg::*;

    localparam int W   = W_DEF;
    localparam int NPW = $clog2(W + 2);

    localparam int M_NORMAL = 0;
    localparam int M_SILENT = 1;
    localparam int M_BOTH   = 2;
    localparam int M_LIAR   = 3;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic           busy, done, err;
    logic [W-1:0]   result;
    logic [NPW-1:0] nprobes;

    compare_search_if #(.W(W)) cif ();

    compare_search #(.W(W), .TMO(TMO_DEF)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .cmp     (cif.master),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .err     (err),
        .nprobes (nprobes)
    );

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   b_val = 0;
    int   mode  = M_NORMAL;
    logic resp_q = 1'b0;
    int   dly = 0;
    int   done_cnt = 0;
    int   probes_q[$];
    int   exp_q[$];
    int   exp_res, exp_err, exp_n;

    // Dataflow magnitude comparator, flags gated by resp_valid; mode bends it into faulty responders.
    assign cif.resp_valid = resp_q;
    assign cif.A_gt_B = resp_q & ((mode == M_BOTH) | ((mode == M_NORMAL) & (int'(cif.A) > b_val)));
    assign cif.A_lt_B = resp_q & ((mode == M_BOTH) | (mode == M_LIAR) | ((mode == M_NORMAL) & (int'(cif.A) < b_val)));
    assign cif.A_eq_B = resp_q & (mode == M_NORMAL) & (int'(cif.A) == b_val);

    always @(negedge clk) begin
        if (!rst_n) begin
            resp_q = 1'b0;
            dly    = 0;
        end else if (resp_q) begin
            resp_q = 1'b0;
            dly    = $urandom_range(0, 2);
        end else if (cif.probe_valid && mode != M_SILENT) begin
            if (dly == 0) begin
                resp_q = 1'b1;
                probes_q.push_back(int'(cif.A));
            end else begin
                dly = dly - 1;
            end
        end
    end

    always @(negedge clk) if (done) done_cnt = done_cnt + 1;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp = n_cmp + 1;
        if (obs !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: textbook binary search over integers, with the faulty-responder variants.
    task automatic model(input int b, input int md);
        int lo, hi, mid;
        exp_q.delete();
        lo = 0; hi = (1 << W) - 1;
        exp_res = 0; exp_err = 0; exp_n = 0;
        if (md == M_SILENT) begin
            exp_err = 1;
        end else begin
            for (int k = 0; k < 64; k++) begin
                mid = (lo + hi) / 2;
                exp_q.push_back(mid);
                exp_n = exp_n + 1;
                if (md == M_BOTH) begin exp_err = 1; break; end
                if (md == M_NORMAL && mid == b) begin exp_res = mid; break; end
                if (md == M_NORMAL && mid > b) hi = mid - 1;
                else lo = mid + 1;
                if (lo > hi) begin exp_err = 1; break; end
            end
        end
    endtask

    // Call at a negedge; leaves the bench at a negedge.
    task automatic run_search(input int b, input int md, input string tag);
        int base, got, busy_n;
        model(b, md);
        base  = probes_q.size();
        b_val = b;
        mode  = md;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk($sformatf("%s/busy_after_start", tag), int'(busy), 1);
        got = 0;
        busy_n = 1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done) begin got = 1; break; end
            if (busy) busy_n = busy_n + 1;
        end
        chk($sformatf("%s/done_seen", tag), got, 1);
        if (got == 1) begin
            chk($sformatf("%s/err", tag), int'(err), exp_err);
            chk($sformatf("%s/nprobes", tag), int'(nprobes), exp_n);
            if (exp_err == 0) chk($sformatf("%s/result", tag), int'(result), exp_res);
            chk($sformatf("%s/busy_in_done", tag), int'(busy), 0);
            chk($sformatf("%s/probe_count", tag), probes_q.size() - base, exp_q.size());
            for (int i = 0; i < exp_q.size() && base + i < probes_q.size(); i++)
                chk($sformatf("%s/probe%0d", tag, i), probes_q[base + i], exp_q[i]);
            if (md == M_SILENT) chk($sformatf("%s/tmo_cycles", tag), busy_n, TMO_DEF);
            @(negedge clk);
            chk($sformatf("%s/done_one_cycle", tag), int'(done), 0);
            chk($sformatf("%s/err_held", tag), int'(err), exp_err);
        end
    endtask

    initial begin
        int got, dc;
        repeat (2) @(negedge clk);
        chk("rst/A", int'(cif.A), 0);
        chk("rst/probe_valid", int'(cif.probe_valid), 0);
        chk("rst/busy", int'(busy), 0);
        chk("rst/done", int'(done), 0);
        chk("rst/err", int'(err), 0);
        chk("rst/result", int'(result), 0);
        chk("rst/nprobes", int'(nprobes), 0);
        rst_n = 1'b1;

        run_search(11, M_NORMAL, "b11");
        run_search(0, M_NORMAL, "b0");
        run_search(15, M_NORMAL, "b15");
        for (int i = 0; i < 20; i++)
            run_search($urandom_range(0, (1 << W) - 1), M_NORMAL, $sformatf("rnd%0d", i));
        run_search(6, M_SILENT, "silent");
        run_search(6, M_BOTH, "both_flags");
        run_search(3, M_LIAR, "liar_lt");

        // Abort during the second probe.
        b_val = 9;
        mode  = M_NORMAL;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        got = 0;
        for (int i = 0; i < 100; i++) begin
            if (nprobes == NPW'(1) && cif.probe_valid) begin got = 1; break; end
            @(negedge clk);
        end
        chk("abort/second_probe_reached", got, 1);
        dc = done_cnt;
        rst_n = 1'b0;
        #1;
        chk("abort/A", int'(cif.A), 0);
        chk("abort/probe_valid", int'(cif.probe_valid), 0);
        chk("abort/busy", int'(busy), 0);
        chk("abort/done", int'(done), 0);
        chk("abort/nprobes", int'(nprobes), 0);
        chk("abort/result", int'(result), 0);
        repeat (3) @(negedge clk);
        chk("abort/no_done_pulse", done_cnt, dc);
        rst_n = 1'b1;
        run_search(5, M_NORMAL, "after_rst_b5");
        run_search($urandom_range(0, (1 << W) - 1), M_NORMAL, "rnd_last");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
